// File: rtl/snake_pkg.sv
// Shared encodings for the snake head stepper: direction codes, FSM states
// and the direction-reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2
  } state_e;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic logic [1:0] reverseDir(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_head_step_dir_fifo2.sv
// Two-entry direction request FIFO. A same-cycle pop and push behaves as
// pop first, then push; a push into a full FIFO is dropped.
module dir_fifo2
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       push_i,
  input  logic [1:0] data_i,
  input  logic       pop_i,
  output logic [1:0] head_o,
  output logic [1:0] newest_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [1:0] slot0_q, slot0_d;
  logic [1:0] slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       doPop;
  logic       doPush;

  // slot0 always holds the oldest entry, so a pop just shifts slot1 down.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    doPop   = pop_i && (count_q != 2'd0);
    doPush  = push_i && (count_q != 2'd2);
    if (doPop) begin
      slot0_d = slot1_q;
      count_d = count_q - 2'd1;
    end
    if (doPush) begin
      if (count_d == 2'd0) begin
        slot0_d = data_i;
      end else begin
        slot1_d = data_i;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      slot0_q <= 2'd0;
      slot1_q <= 2'd0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_o   = slot0_q;
  assign newest_o = (count_q == 2'd2) ? slot1_q : slot0_q;
  assign full_o   = (count_q == 2'd2);
  assign empty_o  = (count_q == 2'd0);

endmodule

// File: rtl/snake_head_step.sv
// Snake head stepper: filters and queues direction requests, advances the head
// one cell per move tick. Define SNAKE_WALL_CRASH_EN to crash on walls instead of wrapping.
module snake_head_step
  import snake_pkg::*;
#(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int START_X = 16,
  parameter int START_Y = 12,
  parameter int XW      = 5,
  parameter int YW      = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          move,
  input  logic          dir_valid,
  input  logic [1:0]    dir_code,
  output logic          dir_ready,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    cur_dir,
  output logic          step_valid,
  output logic          running
`ifdef SNAKE_WALL_CRASH_EN
  ,
  output logic          crash
`endif
);

  state_e        state_q, state_d;
  logic [XW-1:0] headX_q, headX_d;
  logic [YW-1:0] headY_q, headY_d;
  logic [1:0]    curDir_q, curDir_d;
  logic          stepValid_q, stepValid_d;
  logic          running_q, running_d;

  logic [1:0]    fifoHead;
  logic [1:0]    fifoNewest;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          fifoPush;
  logic          fifoPop;

  logic [1:0]    refDir;
  logic          acceptCode;
  logic [1:0]    stepDir;
  logic [XW-1:0] nextX;
  logic [YW-1:0] nextY;
  logic          wraps;
  logic          takeStep;

  dir_fifo2 u_fifo (
    .clk      (clk),
    .clr      (clr),
    .push_i   (fifoPush),
    .data_i   (dir_code),
    .pop_i    (fifoPop),
    .head_o   (fifoHead),
    .newest_o (fifoNewest),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty)
  );

`ifdef SNAKE_WALL_CRASH_EN
  assign dir_ready = !fifoFull && (state_q != ST_CRASH);
  assign crash     = (state_q == ST_CRASH);
`else
  assign dir_ready = !fifoFull;
`endif

  // Requests are judged against the pre-pop newest entry, so a same-cycle pop never changes the verdict.
  assign refDir     = fifoEmpty ? curDir_q : fifoNewest;
  assign acceptCode = ((state_q == ST_WAIT) && fifoEmpty) ||
                      ((dir_code != refDir) && (dir_code != reverseDir(refDir)));
  assign fifoPush   = dir_valid && dir_ready && acceptCode;
  assign stepDir    = fifoEmpty ? curDir_q : fifoHead;

  always_comb begin
    nextX = headX_q;
    nextY = headY_q;
    wraps = 1'b0;
    case (stepDir)
      DIR_UP: begin
        if (headY_q == '0) begin
          nextY = YW'(GRID_H - 1);
          wraps = 1'b1;
        end else begin
          nextY = headY_q - YW'(1);
        end
      end
      DIR_DOWN: begin
        if (headY_q == YW'(GRID_H - 1)) begin
          nextY = '0;
          wraps = 1'b1;
        end else begin
          nextY = headY_q + YW'(1);
        end
      end
      DIR_LEFT: begin
        if (headX_q == '0) begin
          nextX = XW'(GRID_W - 1);
          wraps = 1'b1;
        end else begin
          nextX = headX_q - XW'(1);
        end
      end
      default: begin
        if (headX_q == XW'(GRID_W - 1)) begin
          nextX = '0;
          wraps = 1'b1;
        end else begin
          nextX = headX_q + XW'(1);
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    headX_d     = headX_q;
    headY_d     = headY_q;
    curDir_d    = curDir_q;
    running_d   = running_q;
    stepValid_d = 1'b0;
    fifoPop     = 1'b0;
    takeStep    = 1'b0;

    case (state_q)
      ST_WAIT: takeStep = move && !fifoEmpty;
      ST_RUN:  takeStep = move;
      default: takeStep = 1'b0;
    endcase

    if (takeStep) begin
`ifdef SNAKE_WALL_CRASH_EN
      if (wraps) begin
        state_d = ST_CRASH;
      end else begin
`endif
        fifoPop     = !fifoEmpty;
        curDir_d    = stepDir;
        headX_d     = nextX;
        headY_d     = nextY;
        stepValid_d = 1'b1;
        running_d   = 1'b1;
        state_d     = ST_RUN;
`ifdef SNAKE_WALL_CRASH_EN
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_WAIT;
      headX_q     <= XW'(START_X);
      headY_q     <= YW'(START_Y);
      curDir_q    <= DIR_RIGHT;
      stepValid_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      headX_q     <= headX_d;
      headY_q     <= headY_d;
      curDir_q    <= curDir_d;
      stepValid_q <= stepValid_d;
      running_q   <= running_d;
    end
  end

  assign head_x     = headX_q;
  assign head_y     = headY_q;
  assign cur_dir    = curDir_q;
  assign step_valid = stepValid_q;
  assign running    = running_q;

endmodule

// File: tb/tb_snake_head_step.sv
// Randomized plus directed bench for snake_head_step; a queue-based reference
// model feeds a scoreboard that a separate monitor drains on every step_valid.
module tb_snake_head_step;

  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int START_X = 16;
  localparam int START_Y = 12;
  localparam int XW      = 5;
  localparam int YW      = 5;
`ifdef SNAKE_WALL_CRASH_EN
  localparam bit CRASH_EN = 1'b1;
`else
  localparam bit CRASH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr;
  logic          move;
  logic          dirValid;
  logic [1:0]    dirCode;
  logic          dirReady;
  logic [XW-1:0] headX;
  logic [YW-1:0] headY;
  logic [1:0]    curDir;
  logic          stepValid;
  logic          running;
`ifdef SNAKE_WALL_CRASH_EN
  logic          crash;
`endif

  typedef struct {
    int x;
    int y;
    int d;
    int due;
  } exp_t;

  exp_t sb[$];
  int   fq[$];
  int   mx, my, mdir;
  bit   mrun, mcrash;
  int   tests = 0;
  int   fails = 0;
  int   edgeCount = 0;

  always #5 clk = ~clk;

  snake_head_step #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .START_X(START_X),
    .START_Y(START_Y), .XW(XW), .YW(YW)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .move       (move),
    .dir_valid  (dirValid),
    .dir_code   (dirCode),
    .dir_ready  (dirReady),
    .head_x     (headX),
    .head_y     (headY),
    .cur_dir    (curDir),
    .step_valid (stepValid),
    .running    (running)
`ifdef SNAKE_WALL_CRASH_EN
    ,
    .crash      (crash)
`endif
  );

  task automatic checkVal(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edgeCount);
    end
  endtask

  task automatic modelReset();
    mx = START_X;
    my = START_Y;
    mdir = 1;
    mrun = 1'b0;
    mcrash = 1'b0;
    fq.delete();
  endtask

  // Monitor: every step_valid must match the oldest expectation, on its due edge.
  task automatic checkOutput();
    exp_t e;
    if (stepValid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL spurious_step: got step at (%0d,%0d) expected no step", headX, headY);
      end else begin
        e = sb.pop_front();
        if (headX != e.x || headY != e.y || curDir != e.d || e.due != edgeCount) begin
          fails++;
          $display("[TB] FAIL step: got (%0d,%0d) dir %0d edge %0d expected (%0d,%0d) dir %0d edge %0d",
                   headX, headY, curDir, edgeCount, e.x, e.y, e.d, e.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= edgeCount) begin
      tests++;
      fails++;
      e = sb.pop_front();
      $display("[TB] FAIL missing_step: got no step expected (%0d,%0d) dir %0d", e.x, e.y, e.d);
    end
  endtask

  always @(posedge clk) begin
    edgeCount++;
    #1 checkOutput();
  end

  // One cycle: check registered state, drive inputs, advance the reference model.
  task automatic applyStimulus(input bit clrN, input bit mv, input bit dv, input int code);
    bit ready, accept, wrapped;
    int refd, nd, nx, ny;
    @(negedge clk);
    checkVal("dir_ready", int'(dirReady), int'(fq.size() < 2 && !mcrash));
    checkVal("running", int'(running), int'(mrun));
    checkVal("head_x", int'(headX), mx);
    checkVal("head_y", int'(headY), my);
    checkVal("cur_dir", int'(curDir), mdir);
`ifdef SNAKE_WALL_CRASH_EN
    checkVal("crash", int'(crash), int'(mcrash));
`endif
    clr = clrN;
    move = mv;
    dirValid = dv;
    dirCode = code[1:0];
    if (!clrN) begin
      modelReset();
    end else begin
      ready = (fq.size() < 2) && !mcrash;
      accept = 1'b0;
      if (dv && ready) begin
        refd = (fq.size() != 0) ? fq[$] : mdir;
        accept = (!mrun && fq.size() == 0) || (code != refd && code != (refd ^ 2));
      end
      if (mv && !mcrash && (mrun || fq.size() != 0)) begin
        nd = (fq.size() != 0) ? fq[0] : mdir;
        nx = mx;
        ny = my;
        case (nd)
          0:       begin ny = (my + GRID_H - 1) % GRID_H; wrapped = (my == 0); end
          2:       begin ny = (my + 1) % GRID_H; wrapped = (my == GRID_H - 1); end
          3:       begin nx = (mx + GRID_W - 1) % GRID_W; wrapped = (mx == 0); end
          default: begin nx = (mx + 1) % GRID_W; wrapped = (mx == GRID_W - 1); end
        endcase
        if (CRASH_EN && wrapped) begin
          mcrash = 1'b1;
        end else begin
          if (fq.size() != 0) void'(fq.pop_front());
          mdir = nd;
          mx = nx;
          my = ny;
          mrun = 1'b1;
          sb.push_back('{mx, my, mdir, edgeCount + 1});
        end
      end
      if (accept) fq.push_back(code);
    end
  endtask

  task automatic moves(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 0);
  endtask

  task automatic pushDir(input int code);
    applyStimulus(1, 0, 1, code);
  endtask

  initial begin
    clr = 1'b0;
    move = 1'b0;
    dirValid = 1'b0;
    dirCode = 2'd0;
    modelReset();
    repeat (2) @(posedge clk);

    // Moves before any direction leave the head parked.
    applyStimulus(0, 0, 0, 0);
    moves(3);
    applyStimulus(1, 0, 0, 0);

    // First direction starts the game.
    pushDir(0);
    moves(1);
    applyStimulus(1, 0, 0, 0);

    // Same-direction and reversal requests are dropped.
    pushDir(1);
    moves(1);
    pushDir(3);
    pushDir(1);
    moves(1);
    pushDir(0);
    pushDir(2);
    moves(2);
    applyStimulus(1, 0, 0, 0);

    // Walk to both wrap boundaries.
    applyStimulus(0, 0, 0, 0);
    pushDir(0);
    moves(7);
    pushDir(1);
    moves(16);
    moves(4);
    pushDir(0);
    moves(6);
    applyStimulus(1, 0, 0, 0);

    // Fill the FIFO, then try a third push alongside a move.
    applyStimulus(0, 0, 0, 0);
    pushDir(1);
    moves(1);
    pushDir(0);
    pushDir(3);
    applyStimulus(1, 1, 1, 2);
    moves(2);
    applyStimulus(1, 0, 0, 0);

    // Reset while the FIFO is full and move is high.
    pushDir(0);
    pushDir(3);
    applyStimulus(0, 1, 1, 2);
    applyStimulus(1, 0, 0, 0);
    moves(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
    end
    repeat (3) applyStimulus(1, 0, 0, 0);

    checkVal("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snake_head_step.md
Name: snake_head_step

Overview:
- Consumer of the one-cycle `move` tick produced by the game's move-rate generator.
- Buffers keyboard direction requests, applies at most one per tick, and advances the snake head coordinate on the play grid.
- Emits a one-cycle `step_valid` strobe with the new head position; downstream body/collision logic and VGA map writer consume it.

Parameters:
- GRID_W, 32, grid width in cells; x range 0..GRID_W-1.
- GRID_H, 24, grid height in cells; y range 0..GRID_H-1.
- START_X, 16, head x after reset.
- START_Y, 12, head y after reset.
- XW, 5, head_x width (ceil log2 GRID_W).
- YW, 5, head_y width (ceil log2 GRID_H).

Ports:
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  synchronous reset, active-low; sampled on clk.
- move  in  1  one-cycle advance tick.
- dir_valid  in  1  direction request present.
- dir_code  in  2  requested direction: 0 up, 1 right, 2 down, 3 left.
- dir_ready  out  1  request accepted this cycle when dir_valid&dir_ready.
- head_x  out  XW  current head column.
- head_y  out  YW  current head row.
- cur_dir  out  2  direction applied on last step.
- step_valid  out  1  one-cycle pulse, head_x/head_y just updated.
- running  out  1  high once first direction applied.

Behaviour:
- Reset is synchronous, active-low: clk; clr low on a rising edge resets all state. The polarity and synchronicity are fixed.
- Reset values:
  - head_x=START_X, head_y=START_Y, cur_dir=1 (right)
  - step_valid=0, running=0, dir_ready=1
  - FIFO empty, state=WAIT
- Direction FIFO:
  - 2 entries; dir_ready = not full (registered-state function, no combinational path from move).
- Enqueue filter, applied on handshake:
  - Reference direction = newest FIFO entry if non-empty, else cur_dir.
  - Drop request (handshake still completes) if dir_code equals the reference or equals reference^2 (reversal).
  - In WAIT with FIFO empty, all four codes accepted.
- FSM WAIT:
  - move ignored while FIFO empty.
  - move with FIFO non-empty: pop, cur_dir<=entry, step head, running<=1, go RUN.
- FSM RUN:
  - Each move: if FIFO non-empty pop and cur_dir<=entry; then step head using the (possibly new) cur_dir.
- Step arithmetic:
  - up y-1, down y+1, left x-1, right x+1.
  - Wrap: x=0 left gives GRID_W-1; x=GRID_W-1 right gives 0; same for y with GRID_H. Compare against constants; no modulo.
- Latency: move sampled at edge N; head_x/head_y/cur_dir/step_valid visible after edge N (registered, one cycle); step_valid high exactly one cycle per consumed move.
- Simultaneous push and pop same cycle: pop first, then push; filter reference uses the pre-pop newest entry. Full FIFO: push refused (dir_ready=0) even if pop occurs that cycle.
- move held high multiple cycles: each high cycle is a step. The generator guarantees pulses, so no edge detect is required.
- clr low mid-step: reset wins; step_valid=0 next cycle, FIFO flushed.

Optional Feature:
- Macro SNAKE_WALL_CRASH_EN.
- Defined:
  - A step that would wrap instead enters state CRASH; head unchanged, step_valid not asserted.
  - Extra output port crash (1 bit) goes high and stays high; move and dir requests are ignored (dir_ready=0) until clr.
- Undefined: wrap-around as above; no crash port, no CRASH state.

Decomposition:
- Shared package snake_pkg holds:
  - direction encodings DIR_UP/DIR_RIGHT/DIR_DOWN/DIR_LEFT
  - state encodings WAIT/RUN/CRASH
  - a reverse-direction function (code^2)
- Sub-module dir_fifo2: 2-entry FIFO with push/pop/full/empty/newest outputs. The filter and FSM stay in snake_head_step.

Test Plan:
- Reset, then move pulses with no direction → head stays (16,12), step_valid never high, running=0.
- Push dir 0 (up), then one move → after one cycle head=(16,11), cur_dir=0, step_valid pulses once, running=1.
- RUN with cur_dir=1, push 3 (left) then 1 (right) → both dropped; next move gives x+1. Push 0 then 2 → 2 dropped as reversal of queued 0.
- Head at (31,5) moving right, move → head=(0,5). Head at (4,0) moving up → (4,23). With SNAKE_WALL_CRASH_EN: crash=1, head unchanged.
- Fill FIFO with 0,3 → dir_ready=0; a third push with simultaneous move is refused. Next two moves apply 0 then 3 in order.
- clr low while FIFO holds 2 entries and move asserted → next cycle all reset values, FIFO empty, step_valid=0.
